// File: rtl/max6675_pkg.sv
// Shared definitions for the MAX6675 SPI responder: frame layout, widths and FSM states.
package max6675_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned TEMP_W   = 12;

  localparam int unsigned DUMMY    = 15;
  localparam int unsigned TEMP_MSB = 14;
  localparam int unsigned TEMP_LSB = 3;
  localparam int unsigned OPEN     = 2;
  localparam int unsigned ID       = 1;
  localparam int unsigned TRI      = 0;

  typedef enum logic [1:0] {
    CONVERT,
    READY,
    SHIFT
  } state_t;

  // Assemble a frame as the real device lays it out; dummy, ID and tri-state bits read 0.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [TEMP_W-1:0] temp,
                                                     input logic open);
    logic [FRAME_W-1:0] f;
    f                    = '0;
    f[DUMMY]             = 1'b0;
    f[TEMP_MSB:TEMP_LSB] = temp;
    f[OPEN]              = open;
    f[ID]                = 1'b0;
    f[TRI]               = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/max6675_if.sv
// Pin-level SPI bundle between a thermocouple reader (master) and the responder (slave).
interface max6675_if;
  logic cs_n;
  logic sck;
  logic so;
  logic so_oe;

  modport master (output cs_n, output sck, input so, input so_oe);
  modport slave  (input cs_n, input sck, output so, output so_oe);
endinterface

// File: rtl/max6675_responder_sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin with single-cycle rise/fall strobes.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign rise_c = sync_q[STAGES-1] & ~hist_q;
  assign fall_c = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/max6675_responder.sv
// MAX6675 SPI slave emulator: timed conversion of temp_in/tc_open served as 16-bit frames on so.
module max6675_responder
  import max6675_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CONV_CYCLES = 11000000
) (
  input  logic              clk,
  input  logic              rst,
  max6675_if.slave          spi,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              tc_open,
  output logic              conv_done,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(CONV_CYCLES);
  localparam int unsigned RISE_W = 5;
  localparam logic [CNT_W-1:0]  CONV_LAST = CNT_W'(CONV_CYCLES - 1);
  localparam logic [RISE_W-1:0] RISE_FULL = RISE_W'(FRAME_W);

  state_t              state, state_next;
  logic [CNT_W-1:0]    conv_cnt;
  logic [RISE_W-1:0]   rise_cnt;
  logic [FRAME_W-1:0]  shift_reg;
  logic [TEMP_W-1:0]   data_reg;
  logic                open_reg;

  logic cs_rise, cs_fall, sck_rise, sck_fall;
  logic capture_c, load_c, end_c;
  logic [FRAME_W-1:0] frame_c;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (spi.cs_n),
    .rise_c (cs_rise),
    .fall_c (cs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (spi.sck),
    .rise_c (sck_rise),
    .fall_c (sck_fall)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CONVERT;
    else     state <= state_next;
  end

  // A capture coinciding with a frame start wins: the fresh sample is bypassed into the frame.
  always_comb begin
    state_next = state;
    capture_c  = 1'b0;
    load_c     = 1'b0;
    end_c      = 1'b0;
    case (state)
      CONVERT: begin
        if (conv_cnt == CONV_LAST) begin
          capture_c  = 1'b1;
          state_next = READY;
        end
        if (cs_fall) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end
      end
      READY: begin
        if (cs_fall) begin
          load_c     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          end_c      = 1'b1;
          state_next = CONVERT;
        end
      end
      default: state_next = CONVERT;
    endcase
    frame_c = capture_c ? build_frame(temp_in, tc_open) : build_frame(data_reg, open_reg);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_done  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      data_reg   <= '0;
      open_reg   <= 1'b0;
      shift_reg  <= '0;
      rise_cnt   <= '0;
      conv_cnt   <= '0;
    end else begin
      conv_done  <= capture_c;
      frame_done <= end_c && (rise_cnt == RISE_FULL);

      if (capture_c) begin
        data_reg <= temp_in;
        open_reg <= tc_open;
      end

      if (state == CONVERT && state_next == CONVERT) conv_cnt <= conv_cnt + CNT_W'(1);
      else                                           conv_cnt <= '0;

      if (load_c) begin
        shift_reg <= frame_c;
        rise_cnt  <= '0;
        busy      <= 1'b1;
      end else if (state == SHIFT) begin
        if (end_c)    busy      <= 1'b0;
        if (sck_fall) shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
        if (sck_rise && rise_cnt != RISE_FULL) rise_cnt <= rise_cnt + RISE_W'(1);
      end
    end
  end

  // Output enable tracks the in-frame flag; so is held low whenever the pad is released.
  assign spi.so_oe = busy;
  assign spi.so    = shift_reg[FRAME_W-1] & busy;

endmodule
